// File: rtl/cnt_gate_multi_digit.sv
// cnt_gate_multi_digit: gated multi-digit modulo counter that latches the count at window close.
module cnt_gate_multi_digit #(
    parameter int BUS_SIZE = 4,
    parameter int DIGITS   = 4,
    parameter int MODULO   = 10
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Gate,
    output logic [DIGITS*BUS_SIZE-1:0]   Live,
    output logic [DIGITS*BUS_SIZE-1:0]   Q,
    output logic                         Valid,
    output logic                         Over
);
    localparam logic [BUS_SIZE-1:0] MAX = BUS_SIZE'(MODULO - 1);

    logic [DIGITS*BUS_SIZE-1:0] live_q, live_d, q_q, q_d;
    logic                       gate_q, gate_d, ovf_q, ovf_d;
    logic                       valid_q, valid_d, over_q, over_d;
    logic                       carry, close;
    logic [BUS_SIZE-1:0]        dig;

    always_comb begin
        live_d = live_q;
        dig    = '0;
        carry  = 1'b1;
        // carry leaving the top digit means every digit was at MAX: a full wrap
        for (int i = 0; i < DIGITS; i++) begin
            dig = live_q[i*BUS_SIZE +: BUS_SIZE];
            live_d[i*BUS_SIZE +: BUS_SIZE] = !Gate ? '0 :
                carry ? ((dig == MAX) ? '0 : dig + BUS_SIZE'(1)) : dig;
            carry = carry & (dig == MAX);
        end
        close   = !Gate && gate_q;
        ovf_d   = Gate && (ovf_q || carry);
        gate_d  = Gate;
        valid_d = close;
        q_d     = close ? live_q : q_q;
        over_d  = close ? ovf_q : over_q;
    end

    always_ff @(negedge Clk) begin
        if (Reset) begin
            live_q  <= '0;
            q_q     <= '0;
            gate_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            live_q  <= live_d;
            q_q     <= q_d;
            gate_q  <= gate_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            over_q  <= over_d;
        end
    end

    assign Live  = live_q;
    assign Q     = q_q;
    assign Valid = valid_q;
    assign Over  = over_q;
endmodule

// File: tb/tb_cnt_gate_multi_digit.sv
// tb_cnt_gate_multi_digit: directed checks of a BCD 4-digit instance and a hex 2-digit instance sharing stimulus.
module tb_cnt_gate_multi_digit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gate = 1'b0;
    logic [15:0] live_a, q_a;
    logic [7:0]  live_b, q_b;
    logic        valid_a, over_a, valid_b, over_b;
    int          tests = 0;
    int          fails = 0;

    cnt_gate_multi_digit u_a (
        .Clk(clk), .Reset(rst), .Gate(gate),
        .Live(live_a), .Q(q_a), .Valid(valid_a), .Over(over_a)
    );

    cnt_gate_multi_digit #(.BUS_SIZE(4), .DIGITS(2), .MODULO(16)) u_b (
        .Clk(clk), .Reset(rst), .Gate(gate),
        .Live(live_b), .Q(q_b), .Valid(valid_b), .Over(over_b)
    );

    always #5 clk = ~clk;

    // inputs change and outputs are sampled on rising edges; the DUT acts on falling edges
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        @(posedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_q", q_a, 16'h0000);
        chk("rst_over", {15'd0, over_a}, 16'd0);
        chk("rst_valid", {15'd0, valid_a}, 16'd0);
        chk("rst_live", live_a, 16'h0000);
        chk("rst_b_q", {8'd0, q_b}, 16'h0000);

        gate = 1'b1;
        tick(37);
        chk("w37_live", live_a, 16'h0037);
        gate = 1'b0;
        tick(1);
        chk("w37_q", q_a, 16'h0037);
        chk("w37_over", {15'd0, over_a}, 16'd0);
        chk("w37_valid", {15'd0, valid_a}, 16'd1);
        chk("w37_live_clr", live_a, 16'h0000);
        chk("w37_b_q", {8'd0, q_b}, 16'h0025);
        tick(1);
        chk("w37_valid_fall", {15'd0, valid_a}, 16'd0);
        chk("w37_q_hold", q_a, 16'h0037);

        gate = 1'b1;
        tick(10003);
        chk("w10003_live", live_a, 16'h0003);
        gate = 1'b0;
        tick(1);
        chk("w10003_q", q_a, 16'h0003);
        chk("w10003_over", {15'd0, over_a}, 16'd1);
        chk("w10003_b_q", {8'd0, q_b}, 16'h0013);
        chk("w10003_b_over", {15'd0, over_b}, 16'd1);
        tick(1);
        chk("w10003_over_hold", {15'd0, over_a}, 16'd1);
        gate = 1'b1;
        tick(5);
        gate = 1'b0;
        tick(1);
        chk("w5_q", q_a, 16'h0005);
        chk("w5_over", {15'd0, over_a}, 16'd0);
        tick(1);

        gate = 1'b1;
        tick(999);
        chk("ripple_999", live_a, 16'h0999);
        tick(1);
        chk("ripple_1000", live_a, 16'h1000);
        chk("ripple_b_live", {8'd0, live_b}, 16'h00e8);
        gate = 1'b0;
        tick(1);
        chk("ripple_q", q_a, 16'h1000);
        tick(1);

        gate = 1'b1;
        tick(12);
        gate = 1'b0;
        tick(1);
        chk("b2b_q1", q_a, 16'h0012);
        chk("b2b_valid1", {15'd0, valid_a}, 16'd1);
        gate = 1'b1;
        tick(1);
        chk("b2b_valid_gap", {15'd0, valid_a}, 16'd0);
        chk("b2b_live_restart", live_a, 16'h0001);
        tick(6);
        gate = 1'b0;
        tick(1);
        chk("b2b_q2", q_a, 16'h0007);
        chk("b2b_valid2", {15'd0, valid_a}, 16'd1);
        tick(1);

        gate = 1'b1;
        tick(20);
        chk("rmid_live", live_a, 16'h0020);
        rst = 1'b1;
        tick(1);
        chk("rmid_valid", {15'd0, valid_a}, 16'd0);
        chk("rmid_q", q_a, 16'h0000);
        chk("rmid_live_clr", live_a, 16'h0000);
        rst = 1'b0;
        tick(4);
        chk("rmid_live4", live_a, 16'h0004);
        gate = 1'b0;
        tick(1);
        chk("rmid_q4", q_a, 16'h0004);
        chk("rmid_valid4", {15'd0, valid_a}, 16'd1);
        tick(1);

        gate = 1'b1;
        tick(300);
        gate = 1'b0;
        tick(1);
        chk("hex300_b_q", {8'd0, q_b}, 16'h002c);
        chk("hex300_b_over", {15'd0, over_b}, 16'd1);
        chk("hex300_a_q", q_a, 16'h0300);
        chk("hex300_a_over", {15'd0, over_a}, 16'd0);
        tick(1);

        gate = 1'b1;
        tick(1);
        gate = 1'b0;
        tick(1);
        chk("single_b_q", {8'd0, q_b}, 16'h0001);
        chk("single_b_over", {15'd0, over_b}, 16'd0);
        chk("single_a_q", q_a, 16'h0001);
        chk("single_b_valid", {15'd0, valid_b}, 16'd1);
        tick(1);
        chk("single_b_valid_fall", {15'd0, valid_b}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
